// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared sizes, FSM states, entry type and prefix mask helper for the NDN FIB
package fib_pkg;
  localparam int DEPTH_DEF         = 8;
  localparam int PAYLOAD_BYTES_DEF = 8;
  localparam int PREFIX_W          = 64;
  localparam int LEN_W             = 6;

  typedef enum logic [1:0] {
    I_IDLE,
    I_LOOKUP,
    I_SEND
  } i_state_e;

  typedef enum logic [2:0] {
    D_IDLE,
    D_CAPTURE,
    D_LOOKUP,
    D_OFFER,
    D_SEND
  } d_state_e;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } entry_t;

  // Ones in the top len bit positions, zeros below; len=0 gives an all-zero mask
  function automatic logic [PREFIX_W-1:0] prefix_mask(input logic [LEN_W-1:0] len);
    logic [PREFIX_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < PREFIX_W; i++) begin
      if (i >= PREFIX_W - int'(len)) mask[i] = 1'b1;
    end
    return mask;
  endfunction
endpackage

// File: rtl/fib_cam.sv
// rtl/fib_cam.sv - combinational DEPTH-way prefix compare with first-free search
module fib_cam
  import fib_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  entry_t              entries [DEPTH],
  input  logic [PREFIX_W-1:0] q_prefix,
  input  logic [LEN_W-1:0]    q_len,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                free_found,
  output logic [IDX_W-1:0]    free_idx
);

  logic [PREFIX_W-1:0] mask;

  // Scan from the top index down so the lowest matching or free entry wins
  always_comb begin
    mask       = prefix_mask(q_len);
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].len == q_len) &&
          (((entries[i].prefix ^ q_prefix) & mask) == '0)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ndn_fib_table.sv
// rtl/ndn_fib_table.sv - NDN forwarding table: interest recording/transmit and data match/offer to PIT
module ndn_fib_table
  import fib_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,
  parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREFIX_W-1:0] pit_in_prefix,
  input  logic [LEN_W-1:0]    pit_in_len,
  input  logic                fib_out_bit,
  input  logic                start_send_to_pit,
  input  logic                rejected,
  input  logic [LEN_W-1:0]    data_in_len,
  input  logic [PREFIX_W-1:0] data_in_prefix,
  input  logic                data_ready,
  input  logic [7:0]          data_in,
  output logic [LEN_W-1:0]    pit_out_len,
  output logic [PREFIX_W-1:0] pit_out_prefix,
  output logic                prefix_ready,
  output logic [7:0]          out_data,
  output logic [PREFIX_W-1:0] prefix_out,
  output logic [LEN_W-1:0]    len_out,
  output logic                clk_out
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam int BIDX_W = $clog2(PAYLOAD_BYTES);

  // Table and replacement pointer
  entry_t             fib_q [DEPTH];
  entry_t             fib_d [DEPTH];
  logic [IDX_W-1:0]   rep_ptr_q, rep_ptr_d;

  // Interest side state
  i_state_e            i_state_q, i_state_d;
  logic [PREFIX_W-1:0] i_prefix_q, i_prefix_d;
  logic [LEN_W-1:0]    i_len_q, i_len_d;
  logic                i_write_q, i_write_d;
  logic                i_bump_q, i_bump_d;
  logic [IDX_W-1:0]    i_wr_idx_q, i_wr_idx_d;
  logic [PREFIX_W-1:0] prefix_out_q, prefix_out_d;
  logic [LEN_W-1:0]    len_out_q, len_out_d;
  logic                clk_out_q, clk_out_d;
  logic                i_wr_en;

  // Data side state
  d_state_e            d_state_q, d_state_d;
  logic [PREFIX_W-1:0] d_prefix_q, d_prefix_d;
  logic [LEN_W-1:0]    d_len_q, d_len_d;
  logic [7:0]          d_buf_q [PAYLOAD_BYTES];
  logic [7:0]          d_buf_d [PAYLOAD_BYTES];
  logic [CNT_W-1:0]    d_cnt_q, d_cnt_d;
  logic [IDX_W-1:0]    d_hit_idx_q, d_hit_idx_d;
  logic                prefix_ready_q, prefix_ready_d;
  logic [PREFIX_W-1:0] pit_out_prefix_q, pit_out_prefix_d;
  logic [LEN_W-1:0]    pit_out_len_q, pit_out_len_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                d_inv_en;

  // Lookup results
  logic               i_hit, i_free_found, d_hit, d_free_found;
  logic [IDX_W-1:0]   i_hit_idx, i_free_idx, d_hit_idx, d_free_idx;

  fib_cam #(.DEPTH(DEPTH)) u_cam_interest (
    .entries    (fib_q),
    .q_prefix   (i_prefix_q),
    .q_len      (i_len_q),
    .hit        (i_hit),
    .hit_idx    (i_hit_idx),
    .free_found (i_free_found),
    .free_idx   (i_free_idx)
  );

  fib_cam #(.DEPTH(DEPTH)) u_cam_data (
    .entries    (fib_q),
    .q_prefix   (d_prefix_q),
    .q_len      (d_len_q),
    .hit        (d_hit),
    .hit_idx    (d_hit_idx),
    .free_found (d_free_found),
    .free_idx   (d_free_idx)
  );

  // Both lookup ports read the same table, so their free-slot answers must agree
  always_comb begin
    assert (d_free_found == i_free_found && (!i_free_found || d_free_idx == i_free_idx));
  end

  // Interest FSM: latch request, look up, then record on miss and strobe the prefix out
  always_comb begin
    i_state_d    = i_state_q;
    i_prefix_d   = i_prefix_q;
    i_len_d      = i_len_q;
    i_write_d    = i_write_q;
    i_bump_d     = i_bump_q;
    i_wr_idx_d   = i_wr_idx_q;
    rep_ptr_d    = rep_ptr_q;
    prefix_out_d = prefix_out_q;
    len_out_d    = len_out_q;
    clk_out_d    = 1'b0;
    i_wr_en      = 1'b0;
    case (i_state_q)
      I_IDLE: begin
        if (fib_out_bit) begin
          i_prefix_d = pit_in_prefix;
          i_len_d    = pit_in_len;
          i_state_d  = I_LOOKUP;
        end
      end
      I_LOOKUP: begin
        i_write_d = !i_hit;
        i_bump_d  = !i_hit && !i_free_found;
        if (i_hit)             i_wr_idx_d = i_hit_idx;
        else if (i_free_found) i_wr_idx_d = i_free_idx;
        else                   i_wr_idx_d = rep_ptr_q;
        i_state_d = I_SEND;
      end
      I_SEND: begin
        i_wr_en      = i_write_q;
        if (i_bump_q) rep_ptr_d = rep_ptr_q + 1'b1;
        prefix_out_d = i_prefix_q;
        len_out_d    = i_len_q;
        clk_out_d    = 1'b1;
        i_state_d    = I_IDLE;
      end
      default: i_state_d = I_IDLE;
    endcase
  end

  // Data FSM: capture payload, match, offer to PIT, then stream bytes and retire the entry
  always_comb begin
    d_state_d        = d_state_q;
    d_prefix_d       = d_prefix_q;
    d_len_d          = d_len_q;
    d_buf_d          = d_buf_q;
    d_cnt_d          = d_cnt_q;
    d_hit_idx_d      = d_hit_idx_q;
    prefix_ready_d   = prefix_ready_q;
    pit_out_prefix_d = pit_out_prefix_q;
    pit_out_len_d    = pit_out_len_q;
    out_data_d       = out_data_q;
    d_inv_en         = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (data_ready) begin
          d_prefix_d = data_in_prefix;
          d_len_d    = data_in_len;
          d_buf_d[0] = data_in;
          d_cnt_d    = CNT_W'(1);
          d_state_d  = D_CAPTURE;
        end
      end
      D_CAPTURE: begin
        d_buf_d[d_cnt_q[BIDX_W-1:0]] = data_in;
        if (d_cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
          d_cnt_d   = '0;
          d_state_d = D_LOOKUP;
        end else begin
          d_cnt_d = d_cnt_q + 1'b1;
        end
      end
      D_LOOKUP: begin
        if (d_hit) begin
          d_hit_idx_d      = d_hit_idx;
          prefix_ready_d   = 1'b1;
          pit_out_prefix_d = d_prefix_q;
          pit_out_len_d    = d_len_q;
          d_state_d        = D_OFFER;
        end else begin
          d_state_d = D_IDLE;
        end
      end
      D_OFFER: begin
        if (rejected) begin
          prefix_ready_d = 1'b0;
          d_state_d      = D_IDLE;
        end else if (start_send_to_pit) begin
          out_data_d = d_buf_q[0];
          d_cnt_d    = CNT_W'(1);
          d_state_d  = D_SEND;
        end
      end
      D_SEND: begin
        if (d_cnt_q == CNT_W'(PAYLOAD_BYTES)) begin
          d_inv_en       = 1'b1;
          prefix_ready_d = 1'b0;
          out_data_d     = '0;
          d_state_d      = D_IDLE;
        end else begin
          out_data_d = d_buf_q[d_cnt_q[BIDX_W-1:0]];
          d_cnt_d    = d_cnt_q + 1'b1;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  // Table update: the interest write is applied last so it overrides a same-entry invalidation
  always_comb begin
    fib_d = fib_q;
    if (d_inv_en) fib_d[d_hit_idx_q].valid = 1'b0;
    if (i_wr_en)  fib_d[i_wr_idx_q] = '{valid: 1'b1, prefix: i_prefix_q, len: i_len_q};
  end

  // Interest side and table registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_state_q    <= I_IDLE;
      i_prefix_q   <= '0;
      i_len_q      <= '0;
      i_write_q    <= 1'b0;
      i_bump_q     <= 1'b0;
      i_wr_idx_q   <= '0;
      rep_ptr_q    <= '0;
      prefix_out_q <= '0;
      len_out_q    <= '0;
      clk_out_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fib_q[i] <= '0;
    end else begin
      i_state_q    <= i_state_d;
      i_prefix_q   <= i_prefix_d;
      i_len_q      <= i_len_d;
      i_write_q    <= i_write_d;
      i_bump_q     <= i_bump_d;
      i_wr_idx_q   <= i_wr_idx_d;
      rep_ptr_q    <= rep_ptr_d;
      prefix_out_q <= prefix_out_d;
      len_out_q    <= len_out_d;
      clk_out_q    <= clk_out_d;
      fib_q        <= fib_d;
    end
  end

  // Data side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state_q        <= D_IDLE;
      d_prefix_q       <= '0;
      d_len_q          <= '0;
      d_cnt_q          <= '0;
      d_hit_idx_q      <= '0;
      prefix_ready_q   <= 1'b0;
      pit_out_prefix_q <= '0;
      pit_out_len_q    <= '0;
      out_data_q       <= '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) d_buf_q[i] <= '0;
    end else begin
      d_state_q        <= d_state_d;
      d_prefix_q       <= d_prefix_d;
      d_len_q          <= d_len_d;
      d_cnt_q          <= d_cnt_d;
      d_hit_idx_q      <= d_hit_idx_d;
      prefix_ready_q   <= prefix_ready_d;
      pit_out_prefix_q <= pit_out_prefix_d;
      pit_out_len_q    <= pit_out_len_d;
      out_data_q       <= out_data_d;
      d_buf_q          <= d_buf_d;
    end
  end

  assign pit_out_len    = pit_out_len_q;
  assign pit_out_prefix = pit_out_prefix_q;
  assign prefix_ready   = prefix_ready_q;
  assign out_data       = out_data_q;
  assign prefix_out     = prefix_out_q;
  assign len_out        = len_out_q;
  assign clk_out        = clk_out_q;

endmodule

// File: tb/tb_ndn_fib_table.sv
// tb/tb_ndn_fib_table.sv - randomized self-checking bench for ndn_fib_table against a table model
module tb_ndn_fib_table;
  localparam int DEPTH = 8;
  localparam int PB    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pit_in_prefix = '0;
  logic [5:0]  pit_in_len = '0;
  logic        fib_out_bit = 1'b0;
  logic        start_send_to_pit = 1'b0;
  logic        rejected = 1'b0;
  logic [5:0]  data_in_len = '0;
  logic [63:0] data_in_prefix = '0;
  logic        data_ready = 1'b0;
  logic [7:0]  data_in = '0;
  logic [5:0]  pit_out_len;
  logic [63:0] pit_out_prefix;
  logic        prefix_ready;
  logic [7:0]  out_data;
  logic [63:0] prefix_out;
  logic [5:0]  len_out;
  logic        clk_out;

  ndn_fib_table dut (
    .clk               (clk),
    .rst               (rst),
    .pit_in_prefix     (pit_in_prefix),
    .pit_in_len        (pit_in_len),
    .fib_out_bit       (fib_out_bit),
    .start_send_to_pit (start_send_to_pit),
    .rejected          (rejected),
    .data_in_len       (data_in_len),
    .data_in_prefix    (data_in_prefix),
    .data_ready        (data_ready),
    .data_in           (data_in),
    .pit_out_len       (pit_out_len),
    .pit_out_prefix    (pit_out_prefix),
    .prefix_ready      (prefix_ready),
    .out_data          (out_data),
    .prefix_out        (prefix_out),
    .len_out           (len_out),
    .clk_out           (clk_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference table: what the FIB should hold after each transaction
  bit          m_valid  [DEPTH];
  logic [63:0] m_prefix [DEPTH];
  logic [5:0]  m_len    [DEPTH];
  int          m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i]  = 1'b0;
      m_prefix[i] = '0;
      m_len[i]    = '0;
    end
    m_ptr = 0;
  endfunction

  function automatic bit same_top(input logic [63:0] a, input logic [63:0] b, input logic [5:0] len);
    if (len == 0) return 1'b1;
    return (a >> (64 - len)) == (b >> (64 - len));
  endfunction

  function automatic int model_find(input logic [63:0] p, input logic [5:0] len);
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_len[i] == len && same_top(m_prefix[i], p, len)) return i;
    return -1;
  endfunction

  function automatic void model_interest(input logic [63:0] p, input logic [5:0] len);
    int slot;
    if (model_find(p, len) >= 0) return;
    slot = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_valid[slot]  = 1'b1;
    m_prefix[slot] = p;
    m_len[slot]    = len;
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_eq("rst_clk_out", clk_out, 1'b0);
    end
    check_eq("rst_prefix_ready", prefix_ready, 1'b0);
    check_eq("rst_out_data", out_data, 8'h0);
    check_eq("rst_prefix_out", prefix_out, 64'h0);
    check_eq("rst_len_out", len_out, 6'h0);
    check_eq("rst_pit_out_prefix", pit_out_prefix, 64'h0);
    check_eq("rst_pit_out_len", pit_out_len, 6'h0);
    rst = 1'b1;
  endtask

  task automatic send_interest(input logic [63:0] p, input logic [5:0] len);
    @(negedge clk);
    pit_in_prefix = p;
    pit_in_len    = len;
    fib_out_bit   = 1'b1;
    @(posedge clk); #1;
    fib_out_bit = 1'b0;
    @(posedge clk); #1;
    check_eq("int_early_strobe", clk_out, 1'b0);
    @(posedge clk); #1;
    check_eq("int_strobe", clk_out, 1'b1);
    check_eq("int_prefix_out", prefix_out, p);
    check_eq("int_len_out", len_out, len);
    @(posedge clk); #1;
    check_eq("int_strobe_end", clk_out, 1'b0);
    check_eq("int_prefix_hold", prefix_out, p);
    model_interest(p, len);
  endtask

  // action: 0 accept, 1 reject, 2 accept and reject together (reject wins)
  task automatic send_data(input logic [63:0] p, input logic [5:0] len, input int action,
                           input bit ramp, input bit abort);
    logic [7:0] b [PB];
    int h;
    for (int i = 0; i < PB; i++) b[i] = ramp ? 8'(i + 1) : 8'($urandom);
    h = model_find(p, len);
    @(negedge clk);
    data_ready     = 1'b1;
    data_in_prefix = p;
    data_in_len    = len;
    data_in        = b[0];
    for (int i = 1; i < PB; i++) begin
      @(posedge clk); #1;
      data_in = b[i];
    end
    @(posedge clk); #1;
    data_ready = 1'b0;
    data_in    = '0;
    @(posedge clk); #1;
    check_eq("data_offer", prefix_ready, h >= 0);
    if (h < 0) begin
      repeat (2) begin
        @(posedge clk); #1;
        check_eq("miss_quiet", prefix_ready, 1'b0);
      end
      return;
    end
    check_eq("offer_len", pit_out_len, len);
    check_eq("offer_prefix", pit_out_prefix, p);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      check_eq("offer_hold", prefix_ready, 1'b1);
    end
    rejected          = (action != 0);
    start_send_to_pit = (action != 1);
    @(posedge clk); #1;
    rejected          = 1'b0;
    start_send_to_pit = 1'b0;
    if (action != 0) begin
      check_eq("reject_ready", prefix_ready, 1'b0);
      check_eq("reject_data", out_data, 8'h0);
      return;
    end
    for (int i = 0; i < PB; i++) begin
      check_eq("send_byte", out_data, b[i]);
      check_eq("send_ready", prefix_ready, 1'b1);
      if (abort && i == 2) begin
        rst = 1'b0;
        #2;
        check_eq("abort_ready", prefix_ready, 1'b0);
        check_eq("abort_data", out_data, 8'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        return;
      end
      @(posedge clk); #1;
    end
    check_eq("send_done_ready", prefix_ready, 1'b0);
    check_eq("send_done_data", out_data, 8'h0);
    m_valid[h] = 1'b0;
  endtask

  logic [63:0] pool [4] = '{64'hA5A5_0000_1234_0000, 64'h0F0F_F0F0_5555_AAAA,
                            64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000};
  logic [5:0]  lens [4] = '{6'd0, 6'd8, 6'd16, 6'd63};

  initial begin
    logic [63:0] keep, dp;
    logic [5:0]  l;
    int          k;

    do_reset(10);

    send_interest(64'hA5A5_0000_0000_0000, 6'd16);
    send_data(64'hA500_0000_0000_0000, 6'd8, 0, 1'b1, 1'b0);
    send_data(64'hA5A5_FFFF_FFFF_FFFF, 6'd16, 0, 1'b1, 1'b0);
    send_data(64'hA5A5_FFFF_FFFF_FFFF, 6'd16, 0, 1'b1, 1'b0);

    send_interest(64'hA5A5_0000_0000_0000, 6'd16);
    send_data(64'hA5A5_1111_0000_0000, 6'd16, 2, 1'b0, 1'b0);
    send_data(64'hA5A5_2222_0000_0000, 6'd16, 1, 1'b0, 1'b0);
    send_data(64'hA5A5_3333_0000_0000, 6'd16, 0, 1'b0, 1'b0);

    send_interest(64'h1234_0000_0000_0000, 6'd12);
    send_data(64'h1234_0000_0000_0000, 6'd12, 0, 1'b0, 1'b1);
    send_data(64'h1234_0000_0000_0000, 6'd12, 0, 1'b0, 1'b0);

    do_reset(2);
    for (int i = 0; i < DEPTH + 2; i++) send_interest({8'(8'h10 + i), 56'h0}, 6'd8);
    send_interest({8'h15, 56'hFF}, 6'd8);
    for (int i = 0; i < DEPTH + 2; i++) send_data({8'(8'h10 + i), 56'h77}, 6'd8, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      l = lens[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 0) begin
        send_interest(pool[k], l);
      end else begin
        keep = (l == 0) ? 64'h0 : (~64'h0 << (64 - l));
        dp   = (pool[k] & keep) | ({$urandom, $urandom} & ~keep);
        send_data(dp, l, $urandom_range(0, 2), 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
